// File: rtl/atm_pager_cfg_arb_pkg.sv
// Shared constants for the ATM pager configuration write sequencer:
// register-select codes and the sequencer state encoding.
package atm_pager_cfg_arb_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_X7F7 = 2'b01;
  localparam logic [1:0] SEL_XBF7 = 2'b10;
  localparam logic [1:0] SEL_XFF7 = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/atm_pager_shadow.sv
// Per-window shadow of the last write to each pager register (4 windows x 3 selects x 8 bits).
// Select 00 has no backing register and always reads as zero.
module atm_pager_shadow
  import atm_pager_cfg_arb_pkg::*;
(
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] wr_win,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_win,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data
);

  logic [7:0] mem [0:3][1:3];

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      for (int w = 0; w < 4; w++) begin
        for (int s = 1; s < 4; s++) begin
          mem[w][s] <= 8'h00;
        end
      end
    end else if (we && (wr_sel != SEL_NONE)) begin
      mem[wr_win][wr_sel] <= wr_data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_sel != SEL_NONE) begin
      rd_data = mem[rd_win][rd_sel];
    end
  end

endmodule

// File: rtl/atm_pager_cfg_arb.sv
// Write sequencer for the four ATM pager windows: merges Z80 port writes, the
// post-reset init sequence and host requests onto one registered write bus.
module atm_pager_cfg_arb
  import atm_pager_cfg_arb_pkg::*;
#(
  parameter logic [31:0] INIT_DATA = 32'hFFFF_FFFF,
  parameter logic [1:0]  INIT_SEL  = 2'b11,
  parameter bit          INIT_EN   = 1'b1
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       z_wr,
  input  logic [1:0] z_win,
  input  logic [1:0] z_sel,
  input  logic [7:0] z_data,
  input  logic       h_req,
  input  logic [1:0] h_win,
  input  logic [1:0] h_sel,
  input  logic [7:0] h_data,
  output logic       h_ack,
  output logic [3:0] pw_stb,
  output logic [1:0] pw_sel,
  output logic [7:0] pw_data,
  output logic       init_busy,
  input  logic [1:0] rd_win,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data
);

  localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       issue;
  logic [1:0] iss_win;
  logic [1:0] iss_sel;
  logic [7:0] iss_data;
  logic       ack_nxt;

  // Z80 always wins; a host request is ignored while its previous ack is on the bus
  // so a held request cannot be issued twice.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    issue     = 1'b0;
    iss_win   = 2'b00;
    iss_sel   = 2'b00;
    iss_data  = 8'h00;
    ack_nxt   = 1'b0;
    if (z_wr) begin
      issue    = 1'b1;
      iss_win  = z_win;
      iss_sel  = z_sel;
      iss_data = z_data;
    end else if (state == ST_INIT) begin
      issue    = 1'b1;
      iss_win  = idx;
      iss_sel  = INIT_SEL;
      iss_data = INIT_DATA[{idx, 3'b000} +: 8];
      idx_nxt  = idx + 2'd1;
      if (idx == 2'd3) begin
        state_nxt = ST_IDLE;
      end
    end else if (h_req && !h_ack) begin
      issue    = 1'b1;
      iss_win  = h_win;
      iss_sel  = h_sel;
      iss_data = h_data;
      ack_nxt  = 1'b1;
    end
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      idx     <= 2'd0;
      pw_stb  <= 4'b0000;
      pw_sel  <= 2'b00;
      pw_data <= 8'h00;
      h_ack   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pw_stb  <= issue ? (4'b0001 << iss_win) : 4'b0000;
      pw_sel  <= iss_sel;
      pw_data <= iss_data;
      h_ack   <= ack_nxt;
    end
  end

  assign init_busy = (state == ST_INIT);

  atm_pager_shadow u_shadow (
    .fclk    (fclk),
    .rst_n   (rst_n),
    .we      (issue),
    .wr_win  (iss_win),
    .wr_sel  (iss_sel),
    .wr_data (iss_data),
    .rd_win  (rd_win),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_atm_pager_cfg_arb.sv
// Self-checking bench for atm_pager_cfg_arb: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_atm_pager_cfg_arb;

  localparam logic [31:0] INIT_DATA = 32'h8341_2200;
  localparam logic [1:0]  INIT_SEL  = 2'b11;
  localparam bit          INIT_EN   = 1'b1;

  logic       fclk;
  logic       rst_n;
  logic       z_wr;
  logic [1:0] z_win, z_sel;
  logic [7:0] z_data;
  logic       h_req;
  logic [1:0] h_win, h_sel;
  logic [7:0] h_data;
  logic       h_ack;
  logic [3:0] pw_stb;
  logic [1:0] pw_sel;
  logic [7:0] pw_data;
  logic       init_busy;
  logic [1:0] rd_win, rd_sel;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  atm_pager_cfg_arb #(
    .INIT_DATA (INIT_DATA),
    .INIT_SEL  (INIT_SEL),
    .INIT_EN   (INIT_EN)
  ) dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .z_wr      (z_wr),
    .z_win     (z_win),
    .z_sel     (z_sel),
    .z_data    (z_data),
    .h_req     (h_req),
    .h_win     (h_win),
    .h_sel     (h_sel),
    .h_data    (h_data),
    .h_ack     (h_ack),
    .pw_stb    (pw_stb),
    .pw_sel    (pw_sel),
    .pw_data   (pw_data),
    .init_busy (init_busy),
    .rd_win    (rd_win),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: pending init writes counted down, shadow as a plain array,
  // expected bus contents recomputed from the priority rules each edge.
  bit         m_valid = 1'b0;
  int         m_init_cnt;
  logic [7:0] m_shadow [4][4];
  logic [3:0] e_stb;
  logic [1:0] e_sel;
  logic [7:0] e_data;
  logic       e_ack;
  logic       m_hit, m_ack;
  logic [1:0] m_w, m_s;
  logic [7:0] m_d;

  always @(posedge fclk) begin
    if (!rst_n) begin
      m_valid    = 1'b1;
      m_init_cnt = INIT_EN ? 0 : 4;
      e_stb = 4'b0; e_sel = 2'b0; e_data = 8'h0; e_ack = 1'b0;
      for (int w = 0; w < 4; w++)
        for (int s = 0; s < 4; s++) m_shadow[w][s] = 8'h00;
    end else if (m_valid) begin
      m_hit = 1'b0; m_ack = 1'b0; m_w = 2'b0; m_s = 2'b0; m_d = 8'h0;
      if (z_wr) begin
        m_hit = 1'b1; m_w = z_win; m_s = z_sel; m_d = z_data;
      end else if (m_init_cnt < 4) begin
        m_hit = 1'b1; m_w = 2'(m_init_cnt); m_s = INIT_SEL;
        m_d = 8'(INIT_DATA >> (8 * m_init_cnt));
        m_init_cnt++;
      end else if (h_req && !e_ack) begin
        m_hit = 1'b1; m_ack = 1'b1; m_w = h_win; m_s = h_sel; m_d = h_data;
      end
      e_stb  = m_hit ? (4'b0001 << m_w) : 4'b0000;
      e_sel  = m_s;
      e_data = m_d;
      e_ack  = m_ack;
      if (m_hit && m_s != 2'b00) m_shadow[m_w][m_s] = m_d;
    end
  end

  always @(negedge fclk) begin
    if (m_valid) begin
      checkOutput("pw_stb", pw_stb, e_stb);
      checkOutput("h_ack", h_ack, e_ack);
      checkOutput("init_busy", init_busy, (m_init_cnt < 4));
      checkOutput("rd_data", rd_data, (rd_sel == 2'b00) ? 8'h00 : m_shadow[rd_win][rd_sel]);
      if (e_stb != 4'b0000) begin
        checkOutput("pw_sel", pw_sel, e_sel);
        checkOutput("pw_data", pw_data, e_data);
      end
    end
  end

  task automatic tick();
    @(posedge fclk);
    #2;
  endtask

  task automatic applyStimulus(input logic zw, input logic [1:0] zwin, input logic [1:0] zsel,
                               input logic [7:0] zd);
    z_wr = zw; z_win = zwin; z_sel = zsel; z_data = zd;
  endtask

  task automatic setHost(input logic req, input logic [1:0] win, input logic [1:0] sel,
                         input logic [7:0] d);
    h_req = req; h_win = win; h_sel = sel; h_data = d;
  endtask

  logic [7:0] init_bytes [4];

  initial begin
    init_bytes[0] = 8'h00; init_bytes[1] = 8'h22; init_bytes[2] = 8'h41; init_bytes[3] = 8'h83;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00);
    setHost(1'b0, 2'd0, 2'd0, 8'h00);
    rd_win = 2'd3; rd_sel = 2'd3;
    tick(); tick();
    checkOutput("reset_stb", pw_stb, 8'h00);
    checkOutput("reset_busy", init_busy, 8'h01);
    checkOutput("reset_rd", rd_data, 8'h00);

    // Plain init sequence with no traffic
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("init_stb%0d", k), pw_stb, 8'(4'b0001 << k));
      checkOutput($sformatf("init_data%0d", k), pw_data, init_bytes[k]);
      checkOutput($sformatf("init_sel%0d", k), pw_sel, 8'h03);
      checkOutput($sformatf("init_busy%0d", k), init_busy, (k < 3) ? 8'h01 : 8'h00);
    end
    checkOutput("init_rd_w3", rd_data, 8'h83);
    tick();
    checkOutput("idle_quiet", pw_stb, 8'h00);

    // Held host request issues exactly once
    setHost(1'b1, 2'd1, 2'd2, 8'h01);
    tick();
    checkOutput("host_stb", pw_stb, 8'h02);
    checkOutput("host_ack", h_ack, 8'h01);
    tick();
    checkOutput("host_nodup_stb", pw_stb, 8'h00);
    checkOutput("host_nodup_ack", h_ack, 8'h00);
    setHost(1'b0, 2'd0, 2'd0, 8'h00);
    tick();

    // Z80 and host in the same cycle
    applyStimulus(1'b1, 2'd0, 2'd1, 8'hA5);
    setHost(1'b1, 2'd2, 2'd3, 8'h3C);
    tick();
    checkOutput("zh_first_stb", pw_stb, 8'h01);
    checkOutput("zh_first_ack", h_ack, 8'h00);
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00);
    tick();
    checkOutput("zh_second_stb", pw_stb, 8'h04);
    checkOutput("zh_second_data", pw_data, 8'h3C);
    checkOutput("zh_second_ack", h_ack, 8'h01);
    setHost(1'b0, 2'd0, 2'd0, 8'h00);
    tick();

    // Five back-to-back Z80 writes starve the host
    setHost(1'b1, 2'd3, 2'd1, 8'h77);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'(i), 2'd2, 8'(8'h10 + i));
      tick();
      checkOutput($sformatf("b2b_stb%0d", i), pw_stb, 8'(4'b0001 << (i % 4)));
      checkOutput($sformatf("b2b_ack%0d", i), h_ack, 8'h00);
    end
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00);
    tick();
    checkOutput("b2b_host_stb", pw_stb, 8'h08);
    checkOutput("b2b_host_ack", h_ack, 8'h01);
    setHost(1'b0, 2'd0, 2'd0, 8'h00);
    tick();

    // Z80 write deferring an init step
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("defer_w0", pw_stb, 8'h01);
    applyStimulus(1'b1, 2'd2, 2'd1, 8'h5A);
    tick();
    checkOutput("defer_z_stb", pw_stb, 8'h04);
    checkOutput("defer_z_sel", pw_sel, 8'h01);
    checkOutput("defer_z_data", pw_data, 8'h5A);
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00);
    tick();
    checkOutput("defer_w1", pw_stb, 8'h02);
    checkOutput("defer_w1_data", pw_data, 8'h22);
    tick();
    checkOutput("defer_w2", pw_stb, 8'h04);
    tick();
    checkOutput("defer_w3", pw_stb, 8'h08);
    checkOutput("defer_busy", init_busy, 8'h00);

    // Reset in the middle of init
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    rd_win = 2'd1; rd_sel = 2'd3;
    tick();
    checkOutput("midrst_stb", pw_stb, 8'h00);
    checkOutput("midrst_busy", init_busy, 8'h01);
    checkOutput("midrst_rd", rd_data, 8'h00);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_restart", pw_stb, 8'h01);
    checkOutput("midrst_rd_pending", rd_data, 8'h00);
    tick();
    checkOutput("midrst_rd_rewritten", rd_data, 8'h22);

    // Randomized traffic with a protocol-following host
    for (int c = 0; c < 800; c++) begin
      applyStimulus(($urandom_range(3) == 0), 2'($urandom), 2'($urandom), 8'($urandom));
      if (h_req && h_ack) begin
        if ($urandom_range(1) == 0) setHost(1'b0, 2'd0, 2'd0, 8'h00);
        else setHost(1'b1, 2'($urandom), 2'($urandom), 8'($urandom));
      end else if (!h_req && $urandom_range(2) == 0) begin
        setHost(1'b1, 2'($urandom), 2'($urandom), 8'($urandom));
      end
      rd_win = 2'($urandom);
      rd_sel = 2'($urandom);
      rst_n  = ($urandom_range(149) != 0);
      tick();
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 2'd0, 8'h00);
    setHost(1'b0, 2'd0, 2'd0, 8'h00);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
